multi_chan_accum: RTL and testbench
===================================

Name: multi_chan_accum

Overview:
- Parametrised successor to the per-channel adder pair.
- NUM_CH independent lanes share one clock and reset.
- Each lane accumulates ACC_LEN valid samples, emits the block sum with a sample count and an overflow flag, then restarts.
- Supports early flush and selectable wrap or saturate arithmetic; sits between sample sources and downstream decimation/statistics logic.

Parameters:
- NUM_CH, 4: number of independent lanes.
- WIDTH, 8: unsigned input sample width per lane.
- OUT_WIDTH, 10: accumulator/output width per lane; elaboration error if OUT_WIDTH < WIDTH.
- ACC_LEN, 4: samples per block, >= 1. ACC_LEN=1 gives a registered pass-through.
- SATURATE, 0: 0 means the sum wraps modulo 2^OUT_WIDTH; 1 means the sum clamps at 2^OUT_WIDTH-1.
- CNT_W, derived: clog2(ACC_LEN+1); not overridable.

Ports:
- clk  in  1  single clock; all lanes are synchronous to it.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- din_valid  in  NUM_CH  per-lane sample strobe.
- din  in  NUM_CH*WIDTH  packed samples; lane i occupies [i*WIDTH +: WIDTH].
- flush  in  NUM_CH  per-lane request to emit a partial block.
- dout_valid  out  NUM_CH  one-cycle per-lane result strobe.
- dout  out  NUM_CH*OUT_WIDTH  packed block sums.
- dout_count  out  NUM_CH*CNT_W  number of samples in the emitted sum.
- ovf  out  NUM_CH  overflow (wrap or clamp) occurred within the emitted block; qualified by dout_valid.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears acc, cnt, ovf_sticky, dout, dout_count, dout_valid and ovf to 0 in all lanes. Reset overrides all inputs, and any partial block in progress is discarded.
- Each lane runs a two-state FSM:
  - IDLE: cnt==0, acc==0.
  - ACCUM: 0 < cnt < ACC_LEN.
- sum_ext = acc + zero-extended din, computed at OUT_WIDTH+1 bits. An overflow event is sum_ext >= 2^OUT_WIDTH.
  - Wrap mode: sum = sum_ext mod 2^OUT_WIDTH.
  - Saturate mode: sum = 2^OUT_WIDTH-1 on overflow.
  - Once the sum is clamped, later samples keep it clamped.
- On din_valid without emit: acc <= sum, cnt <= cnt+1, ovf_sticky |= overflow event.
- Emit condition: (din_valid and cnt==ACC_LEN-1) or (flush and (cnt>0 or din_valid)).
- On emit at edge N, the outputs at edge N are:
  - dout <= sum if din_valid, else acc.
  - dout_count <= cnt + din_valid.
  - ovf <= ovf_sticky | (overflow event if din_valid).
  - dout_valid <= 1 for exactly one cycle.
  - acc, cnt and ovf_sticky clear, and the lane returns to IDLE.
- Latency: the result appears the cycle after the final or flush sample.
- A sample coincident with flush is included in the flushed block.
- Flush in IDLE with no din_valid is ignored: no dout_valid pulse, state unchanged.
- Flush and the natural end of a block in the same cycle produce a single emission with count ACC_LEN.
- dout, dout_count and ovf hold their last values while dout_valid=0.
- Back-to-back blocks need no bubble: the sample on the cycle after an emit starts the new block with cnt=1.
- There is no backpressure; downstream must accept a result every cycle.
- Lanes are fully independent; simultaneous activity on all lanes is legal.

Decomposition:
- Package mca_pkg holds:
  - the clog2 function;
  - the mode constants MCA_WRAP=0 and MCA_SAT=1;
  - the lane state enum (MCA_IDLE, MCA_ACCUM).
- Sub-module accum_lane implements one lane: scalar ports, same parameters except NUM_CH.
- The top level generate-loops accum_lane NUM_CH times and slices the packed buses.

Test Plan:
- Defaults. Lane 0 samples 1,2,3,4 on consecutive cycles -> one cycle after the 4th sample: dout0=10, dout_count0=4, ovf0=0, dout_valid0 high for 1 cycle; the other lanes show no valid.
- OUT_WIDTH=9, SATURATE=0. Lane 1 samples 255,255,255,255 -> dout1=508 (1020 mod 512), ovf1=1.
- Same stimulus with SATURATE=1 -> dout1=511, ovf1=1. The next block of 1,1,1,1 -> dout1=4, ovf1=0, proving the sticky flag clears.
- Lane 2 samples 5,6, then a flush with no valid -> dout2=11, count=2.
- Lane 2 flush in IDLE -> no pulse.
- Lane 2 flush coincident with sample 7 after 5 -> dout2=12, count=2.
- Lane 3 samples 9,9 (cnt=2), then rst_n=0 for 1 cycle, then 1,1,1,1 -> no output during or after reset until dout3=4, count=4; all outputs are 0 during reset.
- All four lanes run randomly gapped valids for 1000 cycles alongside a reference model -> every dout/count/ovf matches, with no lost or extra pulses.

Source files
------------

// File: rtl/multi_chan_accum_pkg.sv
// Shared definitions for the multi-channel block accumulator.
package mca_pkg;

    // Arithmetic mode selectors for the SATURATE parameter.
    localparam int MCA_WRAP = 0;
    localparam int MCA_SAT  = 1;

    // Lane state: IDLE holds an empty block, ACCUM holds a partial block.
    typedef enum logic {
        MCA_IDLE  = 1'b0,
        MCA_ACCUM = 1'b1
    } mca_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/multi_chan_accum_if.sv
// Packed sample/result bus of the multi-channel accumulator.
//
// Strobe semantics: there is no ready signal. A lane consumes din whenever
// its din_valid bit is high at a rising clk, and presents a result for exactly
// one cycle with its dout_valid bit high; the consumer must take it that cycle.
// dout, dout_count and ovf hold their last values while dout_valid is low.
interface multi_chan_accum_if #(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 10,
    parameter int ACC_LEN   = 4
);
    import mca_pkg::*;

    localparam int CNT_W = clog2(ACC_LEN + 1);

    logic [NUM_CH-1:0]           din_valid;
    logic [NUM_CH*WIDTH-1:0]     din;
    logic [NUM_CH-1:0]           flush;
    logic [NUM_CH-1:0]           dout_valid;
    logic [NUM_CH*OUT_WIDTH-1:0] dout;
    logic [NUM_CH*CNT_W-1:0]     dout_count;
    logic [NUM_CH-1:0]           ovf;
    // Debug view of each lane FSM: 1 while the lane holds a partial block.
    logic [NUM_CH-1:0]           lane_accum;

    modport master (
        output din_valid, din, flush,
        input  dout_valid, dout, dout_count, ovf, lane_accum
    );

    modport slave (
        input  din_valid, din, flush,
        output dout_valid, dout, dout_count, ovf, lane_accum
    );

endinterface

// File: rtl/multi_chan_accum_lane.sv
// One accumulator lane: sums ACC_LEN samples (or fewer on flush), then emits
// the block sum, sample count and overflow flag for one cycle.
module accum_lane
    import mca_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 10,
    parameter int ACC_LEN   = 4,
    parameter int SATURATE  = MCA_WRAP,
    localparam int CNT_W    = clog2(ACC_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din_valid,
    input  logic [WIDTH-1:0]     din,
    input  logic                 flush,
    output logic                 dout_valid,
    output logic [OUT_WIDTH-1:0] dout,
    output logic [CNT_W-1:0]     dout_count,
    output logic                 ovf,
    output mca_state_e           state
);

    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(ACC_LEN - 1);
    localparam logic [OUT_WIDTH-1:0] MAX_SUM  = '1;

    mca_state_e           state_q, state_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sticky_q, sticky_d;
    logic [OUT_WIDTH-1:0] dout_q, dout_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;

    logic [OUT_WIDTH:0]   sum_ext;
    logic                 ovf_evt;
    logic [OUT_WIDTH-1:0] sum;
    logic                 emit;

    // Datapath: one extra bit catches the carry; saturation pins at all-ones,
    // so a clamped accumulator stays clamped for any later non-zero sample.
    always_comb begin
        sum_ext = {1'b0, acc_q} + (OUT_WIDTH+1)'(din);
        ovf_evt = sum_ext[OUT_WIDTH];
        sum     = sum_ext[OUT_WIDTH-1:0];
        if (SATURATE == MCA_SAT && ovf_evt) begin
            sum = MAX_SUM;
        end
        emit = (din_valid && cnt_q == LAST_CNT) ||
               (flush && (cnt_q != '0 || din_valid));
    end

    // Next-state and result logic; a flush in IDLE without a sample falls
    // through to the defaults and leaves the lane untouched.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        dout_d   = dout_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        if (emit) begin
            dout_d   = din_valid ? sum : acc_q;
            count_d  = cnt_q + CNT_W'(din_valid);
            ovf_d    = sticky_q | (din_valid & ovf_evt);
            valid_d  = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
            state_d  = MCA_IDLE;
        end else if (din_valid) begin
            acc_d    = sum;
            cnt_d    = cnt_q + CNT_W'(1);
            sticky_d = sticky_q | ovf_evt;
            state_d  = MCA_ACCUM;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= MCA_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            dout_q   <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            dout_q   <= dout_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign dout_valid = valid_q;
    assign dout       = dout_q;
    assign dout_count = count_q;
    assign ovf        = ovf_q;
    assign state      = state_q;

endmodule

// File: rtl/multi_chan_accum.sv
// NUM_CH independent block accumulators sharing one clock and reset.
module multi_chan_accum
    import mca_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 10,
    parameter int ACC_LEN   = 4,
    parameter int SATURATE  = MCA_WRAP,
    localparam int CNT_W    = clog2(ACC_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    multi_chan_accum_if.slave bus
);

    // Reject parameter sets the lane arithmetic cannot represent.
    if (OUT_WIDTH < WIDTH) begin : g_bad_width
        $error("multi_chan_accum: OUT_WIDTH must be >= WIDTH");
    end
    if (ACC_LEN < 1) begin : g_bad_len
        $error("multi_chan_accum: ACC_LEN must be >= 1");
    end

    // One lane per channel, each on its own slice of the packed buses.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        logic                 lane_valid;
        logic [OUT_WIDTH-1:0] lane_dout;
        logic [CNT_W-1:0]     lane_count;
        logic                 lane_ovf;
        mca_state_e           lane_state;

        accum_lane #(
            .WIDTH     (WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .ACC_LEN   (ACC_LEN),
            .SATURATE  (SATURATE)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .din_valid  (bus.din_valid[i]),
            .din        (bus.din[i*WIDTH +: WIDTH]),
            .flush      (bus.flush[i]),
            .dout_valid (lane_valid),
            .dout       (lane_dout),
            .dout_count (lane_count),
            .ovf        (lane_ovf),
            .state      (lane_state)
        );

        assign bus.dout_valid[i]                     = lane_valid;
        assign bus.dout[i*OUT_WIDTH +: OUT_WIDTH]    = lane_dout;
        assign bus.dout_count[i*CNT_W +: CNT_W]      = lane_count;
        assign bus.ovf[i]                            = lane_ovf;
        assign bus.lane_accum[i]                     = (lane_state == MCA_ACCUM);
    end

endmodule

// File: tb/tb_multi_chan_accum.sv
// Bench for multi_chan_accum: three instances (default, 9-bit wrap, 9-bit
// saturate) share one stimulus stream; directed vectors then a random run
// against a block-total reference model.
module tb_multi_chan_accum;
    import mca_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    // Clock and reset
    always #5 clk = ~clk;

    multi_chan_accum_if #(.NUM_CH(4), .WIDTH(8), .OUT_WIDTH(10), .ACC_LEN(4)) bus_def ();
    multi_chan_accum_if #(.NUM_CH(4), .WIDTH(8), .OUT_WIDTH(9),  .ACC_LEN(4)) bus_w9 ();
    multi_chan_accum_if #(.NUM_CH(4), .WIDTH(8), .OUT_WIDTH(9),  .ACC_LEN(4)) bus_s9 ();

    multi_chan_accum #(.NUM_CH(4), .WIDTH(8), .OUT_WIDTH(10), .ACC_LEN(4), .SATURATE(MCA_WRAP))
        dut_def (.clk(clk), .rst_n(rst_n), .bus(bus_def.slave));
    multi_chan_accum #(.NUM_CH(4), .WIDTH(8), .OUT_WIDTH(9), .ACC_LEN(4), .SATURATE(MCA_WRAP))
        dut_w9 (.clk(clk), .rst_n(rst_n), .bus(bus_w9.slave));
    multi_chan_accum #(.NUM_CH(4), .WIDTH(8), .OUT_WIDTH(9), .ACC_LEN(4), .SATURATE(MCA_SAT))
        dut_s9 (.clk(clk), .rst_n(rst_n), .bus(bus_s9.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard entry: {dut, lane[1:0], ovf, count[2:0], dout[8:0]}
    logic [15:0] exp_q[$];
    int m_cnt[2][4];
    int m_tot[2][4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Driver: apply one cycle of inputs to every instance, return at negedge.
    task automatic drive(input logic [3:0] v, input logic [3:0] f, input logic [31:0] x);
        bus_def.din_valid = v; bus_def.flush = f; bus_def.din = x;
        bus_w9.din_valid  = v; bus_w9.flush  = f; bus_w9.din  = x;
        bus_s9.din_valid  = v; bus_s9.flush  = f; bus_s9.din  = x;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] lw(input int l, input logic [7:0] val);
        logic [31:0] w;
        w = '0;
        w[l*8 +: 8] = val;
        return w;
    endfunction

    function automatic logic [9:0] def_dout(input int l);
        return bus_def.dout[l*10 +: 10];
    endfunction

    function automatic logic [2:0] def_cnt(input int l);
        return bus_def.dout_count[l*3 +: 3];
    endfunction

    function automatic logic [15:0] obs(input int d, input int l);
        logic [15:0] e;
        if (d == 0) e = {1'b0, 2'(l), bus_w9.ovf[l], bus_w9.dout_count[l*3 +: 3], bus_w9.dout[l*9 +: 9]};
        else        e = {1'b1, 2'(l), bus_s9.ovf[l], bus_s9.dout_count[l*3 +: 3], bus_s9.dout[l*9 +: 9]};
        return e;
    endfunction

    // Reference model: track the true integer block total; overflow occurred
    // iff the total reached 512, wrap keeps total mod 512, saturate clamps.
    task automatic model_step(input logic [3:0] v, input logic [3:0] f, input logic [31:0] x);
        for (int d = 0; d < 2; d++) begin
            for (int l = 0; l < 4; l++) begin
                int c;
                int t;
                int s;
                c = m_cnt[d][l];
                t = m_tot[d][l];
                if (v[l]) begin
                    c = c + 1;
                    t = t + int'(x[l*8 +: 8]);
                end
                if ((v[l] && c == 4) || (f[l] && c > 0)) begin
                    s = (d == 1) ? ((t > 511) ? 511 : t) : (t % 512);
                    exp_q.push_back({1'(d), 2'(l), (t >= 512), 3'(c), 9'(s)});
                    c = 0;
                    t = 0;
                end
                m_cnt[d][l] = c;
                m_tot[d][l] = t;
            end
        end
    endtask

    task automatic random_phase();
        logic [3:0]  v;
        logic [3:0]  f;
        logic [31:0] x;
        logic [15:0] e;
        for (int d = 0; d < 2; d++)
            for (int l = 0; l < 4; l++) begin
                m_cnt[d][l] = 0;
                m_tot[d][l] = 0;
            end
        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int l = 0; l < 4; l++) begin
                v[l] = ($urandom_range(0, 9) < 6);
                f[l] = ($urandom_range(0, 9) == 0);
                x[l*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(180, 255))
                                                          : 8'($urandom_range(0, 255));
            end
            model_step(v, f, x);
            drive(v, f, x);
            for (int d = 0; d < 2; d++) begin
                for (int l = 0; l < 4; l++) begin
                    logic vo;
                    vo = (d == 0) ? bus_w9.dout_valid[l] : bus_s9.dout_valid[l];
                    if (vo) begin
                        if (exp_q.size() == 0) begin
                            check_eq("rnd_extra_pulse", 32'(obs(d, l)), 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            check_eq("rnd_result", 32'(obs(d, l)), 32'(e));
                        end
                    end
                end
            end
            check_eq("rnd_missing_pulse", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'h0, 4'h0, 32'h0);
        drive(4'h0, 4'h0, 32'h0);

        // Reset state
        check_eq("rst_valid", 32'(bus_def.dout_valid), 0);
        check_eq("rst_dout", 32'(bus_def.dout), 0);
        check_eq("rst_count", 32'(bus_def.dout_count), 0);
        check_eq("rst_ovf", 32'(bus_def.ovf), 0);
        check_eq("rst_state", 32'(bus_def.lane_accum), 0);
        check_eq("rst_state_w9", 32'(bus_w9.lane_accum), 0);
        rst_n = 1'b1;

        // Lane 0: 1,2,3,4
        drive(4'h1, 4'h0, lw(0, 1));
        drive(4'h1, 4'h0, lw(0, 2));
        drive(4'h1, 4'h0, lw(0, 3));
        check_eq("t1_no_early", 32'(bus_def.dout_valid), 0);
        check_eq("t1_state_accum", 32'(bus_def.lane_accum), 1);
        drive(4'h1, 4'h0, lw(0, 4));
        check_eq("t1_valid", 32'(bus_def.dout_valid), 1);
        check_eq("t1_dout", 32'(def_dout(0)), 10);
        check_eq("t1_count", 32'(def_cnt(0)), 4);
        check_eq("t1_ovf", 32'(bus_def.ovf[0]), 0);
        check_eq("t1_state_idle", 32'(bus_def.lane_accum), 0);
        drive(4'h0, 4'h0, 32'h0);
        check_eq("t1_one_pulse", 32'(bus_def.dout_valid), 0);
        check_eq("t1_hold", 32'(def_dout(0)), 10);

        // Lane 1: 255 x4 -> wrap 508, saturate 511, 10-bit 1020
        repeat (4) drive(4'h2, 4'h0, lw(1, 255));
        check_eq("w9_valid", 32'(bus_w9.dout_valid), 2);
        check_eq("w9_dout", 32'(bus_w9.dout[9 +: 9]), 508);
        check_eq("w9_ovf", 32'(bus_w9.ovf[1]), 1);
        check_eq("s9_dout", 32'(bus_s9.dout[9 +: 9]), 511);
        check_eq("s9_ovf", 32'(bus_s9.ovf[1]), 1);
        check_eq("s9_count", 32'(bus_s9.dout_count[3 +: 3]), 4);
        check_eq("def_1020", 32'(def_dout(1)), 1020);
        check_eq("def_no_ovf", 32'(bus_def.ovf[1]), 0);
        repeat (4) drive(4'h2, 4'h0, lw(1, 1));
        check_eq("s9_next_dout", 32'(bus_s9.dout[9 +: 9]), 4);
        check_eq("s9_sticky_clr", 32'(bus_s9.ovf[1]), 0);

        // Lane 2: 5,6 then flush without a sample
        drive(4'h4, 4'h0, lw(2, 5));
        drive(4'h4, 4'h0, lw(2, 6));
        drive(4'h0, 4'h4, 32'h0);
        check_eq("fl_valid", 32'(bus_def.dout_valid), 4);
        check_eq("fl_dout", 32'(def_dout(2)), 11);
        check_eq("fl_count", 32'(def_cnt(2)), 2);

        // Lane 2: flush in IDLE is ignored
        drive(4'h0, 4'h4, 32'h0);
        check_eq("fl_idle_valid", 32'(bus_def.dout_valid), 0);
        check_eq("fl_idle_state", 32'(bus_def.lane_accum), 0);

        // Lane 2: flush coincident with a sample
        drive(4'h4, 4'h0, lw(2, 5));
        drive(4'h4, 4'h4, lw(2, 7));
        check_eq("flc_valid", 32'(bus_def.dout_valid), 4);
        check_eq("flc_dout", 32'(def_dout(2)), 12);
        check_eq("flc_count", 32'(def_cnt(2)), 2);

        // Lane 0: flush on the natural last sample gives one emission
        repeat (3) drive(4'h1, 4'h0, lw(0, 2));
        drive(4'h1, 4'h1, lw(0, 2));
        check_eq("fle_valid", 32'(bus_def.dout_valid), 1);
        check_eq("fle_dout", 32'(def_dout(0)), 8);
        check_eq("fle_count", 32'(def_cnt(0)), 4);
        drive(4'h0, 4'h0, 32'h0);
        check_eq("fle_single", 32'(bus_def.dout_valid), 0);

        // Lane 3: reset discards a partial block and overrides inputs
        drive(4'h8, 4'h0, lw(3, 9));
        drive(4'h8, 4'h0, lw(3, 9));
        rst_n = 1'b0;
        drive(4'h8, 4'h8, lw(3, 9));
        check_eq("mrst_valid", 32'(bus_def.dout_valid), 0);
        check_eq("mrst_dout", 32'(bus_def.dout), 0);
        check_eq("mrst_count", 32'(bus_def.dout_count), 0);
        check_eq("mrst_ovf", 32'(bus_def.ovf), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(4'h8, 4'h0, lw(3, 1));
            check_eq("mrst_no_early", 32'(bus_def.dout_valid), 0);
        end
        drive(4'h8, 4'h0, lw(3, 1));
        check_eq("mrst_blk_valid", 32'(bus_def.dout_valid), 8);
        check_eq("mrst_blk_dout", 32'(def_dout(3)), 4);
        check_eq("mrst_blk_count", 32'(def_cnt(3)), 4);

        // All lanes, random gaps, against the reference model
        random_phase();
        drive(4'h0, 4'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
